// File: rtl/vga_key_highlighter.sv
// ---------------------------------------------------------------------------
// vga_key_highlighter
//
// Purpose:
//   Watches a vector of key levels and, whenever a key's level differs from
//   what was last drawn for it, plots a small box of pixels over that key's
//   on-screen target. Pressed targets are drawn in HI_COLOUR; released
//   targets are redrawn in their base colour (black for the raised keys at
//   Y=96, white for everything else). One pixel per cycle is emitted on
//   oX/oY/oColour with oPlot as the write strobe.
//
// Build option:
//   HIGHLIGHT_ERASE_EN  defined   : releases redraw the box in base colour.
//                       undefined : releases only clear the shadow state;
//                                   only presses are drawn.
//
// Ports:
//   iClock   in   rising-edge clock
//   iReset   in   synchronous active-high reset
//   iKeys    in   [NUM_KEYS] key levels, bit n -> target n (1 = pressed)
//   oX       out  [9] pixel X (registered)
//   oY       out  [8] pixel Y (registered)
//   oColour  out  [3] pixel colour (registered)
//   oPlot    out  pixel write enable (registered)
//   oBusy    out  high while the FSM is drawing a box
// ---------------------------------------------------------------------------
module vga_key_highlighter #(
  parameter int         BOX_W     = 4,
  parameter int         BOX_H     = 4,
  parameter int         NUM_KEYS  = 16,
  parameter logic [2:0] HI_COLOUR = 3'b110
) (
  input  logic                iClock,
  input  logic                iReset,
  input  logic [NUM_KEYS-1:0] iKeys,
  output logic [8:0]          oX,
  output logic [7:0]          oY,
  output logic [2:0]          oColour,
  output logic                oPlot,
  output logic                oBusy
);

  localparam int         NPIX     = BOX_W * BOX_H;
  localparam logic [7:0] LAST_CNT = 8'(NPIX - 1);
  localparam logic [3:0] LAST_COL = 4'(BOX_W - 1);
  localparam logic [3:0] LAST_KEY = 4'(NUM_KEYS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_t;

  // Fixed target origin table.
  function automatic logic [8:0] f_org_x(input logic [3:0] n);
    logic [8:0] x;
    case (n)
      4'd0:  x = 9'd66;
      4'd1:  x = 9'd81;
      4'd2:  x = 9'd99;
      4'd3:  x = 9'd112;
      4'd4:  x = 9'd131;
      4'd5:  x = 9'd161;
      4'd6:  x = 9'd174;
      4'd7:  x = 9'd192;
      4'd8:  x = 9'd209;
      4'd9:  x = 9'd224;
      4'd10: x = 9'd245;
      4'd11: x = 9'd254;
      4'd12: x = 9'd103;
      4'd13: x = 9'd71;
      4'd14: x = 9'd153;
      4'd15: x = 9'd183;
    endcase
    return x;
  endfunction

  function automatic logic [7:0] f_org_y(input logic [3:0] n);
    logic [7:0] y;
    case (n)
      4'd1, 4'd3, 4'd6, 4'd8, 4'd10:            y = 8'd96;
      4'd12, 4'd13, 4'd14, 4'd15:               y = 8'd169;
      default:                                  y = 8'd124;
    endcase
    return y;
  endfunction

  // Raised keys (Y=96) are black, everything else white.
  function automatic logic [2:0] f_base(input logic [3:0] n);
    return (f_org_y(n) == 8'd96) ? 3'b000 : 3'b111;
  endfunction

  // Index ptr+i wrapped into 0..NUM_KEYS-1 (ptr is always < NUM_KEYS).
  function automatic logic [3:0] f_wrap(input logic [3:0] p, input int i);
    int s;
    s = int'(p) + i;
    if (s >= NUM_KEYS) s = s - NUM_KEYS;
    return 4'(s);
  endfunction

  state_t      r_state;
  logic [15:0] r_skeys;   // last drawn level of each target
  logic [3:0]  r_ptr;     // round-robin start point
  logic [3:0]  r_idx;     // target being drawn
  logic        r_tgt;     // level being drawn for r_idx
  logic [7:0]  r_cnt;     // pixel index within the box
  logic [3:0]  r_col;     // cnt mod BOX_W, kept as a counter to avoid a divider
  logic [3:0]  r_row;     // cnt div BOX_W

  logic [15:0] w_keys;
  logic [15:0] w_cand;
  logic        w_found;
  logic [3:0]  w_sel;

  // Targets beyond NUM_KEYS read as permanently released and never dirty.
  assign w_keys = 16'(iKeys);

`ifdef HIGHLIGHT_ERASE_EN
  assign w_cand = w_keys ^ r_skeys;
`else
  // Releases are folded into the shadow directly; only presses get drawn.
  logic [15:0] w_rel;
  assign w_rel  = r_skeys & ~w_keys;
  assign w_cand = w_keys & ~r_skeys;
`endif

  // Lowest candidate at or above r_ptr, wrapping back to 0.
  always_comb begin
    w_found = 1'b0;
    w_sel   = 4'd0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (!w_found && w_cand[f_wrap(r_ptr, i)]) begin
        w_found = 1'b1;
        w_sel   = f_wrap(r_ptr, i);
      end
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state <= IDLE;
      r_skeys <= 16'd0;
      r_ptr   <= 4'd0;
      r_idx   <= 4'd0;
      r_tgt   <= 1'b0;
      r_cnt   <= 8'd0;
      r_col   <= 4'd0;
      r_row   <= 4'd0;
      oPlot   <= 1'b0;
      oX      <= 9'd0;
      oY      <= 8'd0;
      oColour <= 3'b000;
    end else begin
      case (r_state)
        IDLE: begin
          oPlot <= 1'b0;
`ifndef HIGHLIGHT_ERASE_EN
          r_skeys <= r_skeys & ~w_rel;
`endif
          if (w_found) begin
            r_state <= DRAW;
            r_idx   <= w_sel;
            r_tgt   <= w_keys[w_sel];
            r_ptr   <= (w_sel == LAST_KEY) ? 4'd0 : w_sel + 4'd1;
            r_cnt   <= 8'd0;
            r_col   <= 4'd0;
            r_row   <= 4'd0;
          end
        end
        DRAW: begin
          // idx/tgt were latched at selection, so key changes now cannot
          // disturb this box; they remain dirty for a later pass.
          oPlot   <= 1'b1;
          oX      <= f_org_x(r_idx) + {5'd0, r_col};
          oY      <= f_org_y(r_idx) + {4'd0, r_row};
          oColour <= r_tgt ? HI_COLOUR : f_base(r_idx);
          if (r_cnt == LAST_CNT) begin
            r_state        <= IDLE;
            r_skeys[r_idx] <= r_tgt;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (r_col == LAST_COL) begin
              r_col <= 4'd0;
              r_row <= r_row + 4'd1;
            end else begin
              r_col <= r_col + 4'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign oBusy = (r_state == DRAW);

endmodule

// File: doc/vga_key_highlighter.md
VGA_KEY_HIGHLIGHTER -- requirements
Module: vga_key_highlighter

Interface
REQ-001 Parameter BOX_W, default 4: highlight box width in pixels (1..16).
REQ-002 Parameter BOX_H, default 4: highlight box height in pixels (1..16).
REQ-003 Parameter NUM_KEYS, default 16: number of tracked targets (1..16).
REQ-004 Parameter HI_COLOUR, default 3'b110: colour used for pressed targets.
REQ-005 Port iClock, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port iReset, input, 1: synchronous, active-high reset.
REQ-007 Port iKeys, input, NUM_KEYS: level per target (1 = pressed/active); bit n maps to target n.
REQ-008 Port oX, output, 9: pixel X coordinate.
REQ-009 Port oY, output, 8: pixel Y coordinate.
REQ-010 Port oColour, output, 3: pixel colour.
REQ-011 Port oPlot, output, 1: pixel write enable, one pixel per asserted cycle.
REQ-012 Port oBusy, output, 1: high while a box is being drawn.

Function
REQ-013 Target origin table (X,Y), SHALL be fixed:
- 0:(66,124); 1:(81,96); 2:(99,124); 3:(112,96); 4:(131,124); 5:(161,124)
- 6:(174,96); 7:(192,124); 8:(209,96); 9:(224,124); 10:(245,96); 11:(254,124)
- 12:(103,169) oct+; 13:(71,169) oct-; 14:(153,169) ADSR+; 15:(183,169) ADSR-
REQ-014 Base colour SHALL be 3'b000 for targets with Y=96 and 3'b111 for all others.
REQ-015 A shadow register sKeys (NUM_KEYS bits) SHALL hold the last drawn state of each target; dirty = iKeys XOR sKeys.
REQ-016 FSM states: IDLE, DRAW.
- IDLE -> DRAW when dirty is non-zero.
- DRAW -> IDLE after the last pixel.
REQ-017 In IDLE, selection SHALL be round-robin: the lowest dirty index at or above ptr, wrapping to 0. Latch idx and tgt = iKeys[idx]. Set ptr = idx+1 mod NUM_KEYS.
REQ-018 In DRAW, pixel counter cnt SHALL run 0..BOX_W*BOX_H-1, one step per cycle. Raster order:
- x = X[idx] + (cnt mod BOX_W)
- y = Y[idx] + (cnt div BOX_W)
- Sums wrap modulo 2^9 and 2^8 respectively.
REQ-019 oColour SHALL be HI_COLOUR when tgt=1, else the base colour of idx.
REQ-020 oX, oY, oColour and oPlot SHALL be registered. The first pixel appears with oPlot=1 two cycles after the edge where dirty first became non-zero in IDLE.
REQ-021 oPlot SHALL be high for exactly BOX_W*BOX_H consecutive cycles per box, and low otherwise.
REQ-022 On the last pixel, sKeys[idx] SHALL be set to tgt.
REQ-023 iKeys[idx] changing during DRAW SHALL NOT alter the box in progress. The target stays dirty and is redrawn later.
REQ-024 Simultaneous dirty targets SHALL be serviced one box at a time in round-robin order. None is dropped.
REQ-025 Targets with index >= NUM_KEYS SHALL be ignored.
REQ-026 oBusy SHALL equal (state == DRAW).

Reset
REQ-027 While iReset=1 at a rising edge, the block SHALL set:
- state=IDLE, sKeys=0, ptr=0, cnt=0
- oPlot=0, oX=0, oY=0, oColour=3'b000, oBusy=0
REQ-028 Reset mid-DRAW SHALL abort the box with no further oPlot. Held keys are redrawn from pixel 0 after reset releases.

Configuration
REQ-029 Macro HIGHLIGHT_ERASE_EN defined: a release (dirty with iKeys=0) SHALL redraw the box in base colour per REQ-019.
REQ-030 Macro HIGHLIGHT_ERASE_EN undefined:
- Only presses (iKeys=1, sKeys=0) SHALL start a DRAW.
- On a release, IDLE SHALL clear sKeys[n] in one cycle without plotting.
- Release clears SHALL be handled for all released bits at once, before any press selection in that cycle.

Verification (defaults, HIGHLIGHT_ERASE_EN defined unless stated)
REQ-031 Reset, then iKeys=0x0001 -> oPlot high 16 cycles; first pixel (66,124) colour 110; last pixel (69,127); then oBusy=0 and sKeys=0x0001.
REQ-032 iKeys=0x0012 in one cycle -> target 1 box at (81..84,96..99) first, then target 4 box at (131..134,124..127); 32 plot cycles contiguous except for the IDLE gap between boxes.
REQ-033 After REQ-031, iKeys=0x0000 -> 16 pixels at (66..69,124..127) colour 111. With HIGHLIGHT_ERASE_EN undefined -> no oPlot, and sKeys=0 one cycle later.
REQ-034 iReset=1 at pixel 5 of target 12 while iKeys=0x1000 held -> oPlot=0 the next cycle. After release, a full 16-pixel box starts at (103,169) colour 110.
REQ-035 Key 3 press/release toggled every 8 cycles while key 10 is held -> key 10 box (245,96) is drawn within two box periods, showing round-robin fairness; BOX_W=8, BOX_H=2 run gives 16-pixel boxes with x stepping 0..7 across two rows.
